// File: rtl/const_mult_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | const_mult_pkg                                                       |
// | Shared types and elaboration-time helpers for const_mult_seq.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package const_mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // K is below 2**31, so 31 mask bits always cover it.
   localparam int c_K_W = 31;

   function automatic int popcount(input int v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   function automatic int y_width(input int w, input int k);
      longint lim;
      int     b;
      lim = longint'(k) + 64'sd1;
      b   = 0;
      while ((64'sd1 <<< b) < lim) b++;
      if (b < 1) b = 1;
      return w + b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/const_mult_seq_lsb_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | const_mult_lsb_sel                                                   |
// | Lowest-set-bit priority encoder with a last-set-bit flag.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module const_mult_lsb_sel #(
   parameter int N     = 31,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     mask,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   logic [N-1:0] w_rest;

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) idx = i[IDX_W-1:0];
      end
   end

   // Clearing the lowest set bit leaves nothing when it was the only one.
   assign w_rest = mask & (mask - {{(N-1){1'b0}}, 1'b1});
   assign last   = (mask != '0) && (w_rest == '0);

endmodule
`default_nettype wire

// File: rtl/const_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | const_mult_seq                                                       |
// | Handshaked shift-add multiplier by constant K; optional self-check   |
// | enabled by defining CONST_MULT_SEQ_CHECK_EN.                         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module const_mult_seq
   import const_mult_pkg::*;
#(
   parameter int W = 32,
   parameter int K = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [W-1:0]                 in_a,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [y_width(W, K)-1:0]     out_y,
   output logic                         busy
`ifdef CONST_MULT_SEQ_CHECK_EN
   ,
   output logic                         fail
`endif
);

   localparam int Y_W     = y_width(W, K);
   localparam int c_idx_w = $clog2(c_K_W);
   localparam logic [c_K_W-1:0] c_k_mask = c_K_W'(K);

   state_t             r_state;
   logic [Y_W-1:0]     r_a;
   logic [Y_W-1:0]     r_acc;
   logic [c_K_W-1:0]   r_mask;
   logic               r_out_vld;
   logic [c_idx_w-1:0] w_idx;
   logic               w_last;
   logic [Y_W-1:0]     w_addend;

   const_mult_lsb_sel #(
      .N     (c_K_W),
      .IDX_W (c_idx_w)
   ) u_lsb_sel (
      .mask (r_mask),
      .idx  (w_idx),
      .last (w_last)
   );

   // r_a is already Y_W wide, so the shift cannot lose high bits.
   assign w_addend = r_a << w_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_acc     <= '0;
         r_mask    <= '0;
         r_out_vld <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_vld) begin
                  r_a    <= Y_W'(in_a);
                  r_acc  <= '0;
                  r_mask <= c_k_mask;
                  if (K != 0) begin
                     r_state <= ACCUM;
                  end else begin
                     r_state   <= DONE;
                     r_out_vld <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               r_acc  <= r_acc + w_addend;
               r_mask <= r_mask & ~(c_K_W'(1) << w_idx);
               if (w_last) begin
                  r_state   <= DONE;
                  r_out_vld <= 1'b1;
               end
            end
            DONE: begin
               if (out_rdy) begin
                  r_state   <= IDLE;
                  r_out_vld <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_out_vld <= 1'b0;
            end
         endcase
      end
   end

   assign in_rdy  = (r_state == IDLE);
   assign busy    = (r_state != IDLE);
   assign out_vld = r_out_vld;
   assign out_y   = r_acc;

`ifdef CONST_MULT_SEQ_CHECK_EN
   logic [Y_W-1:0] w_ref;
   logic           r_fail;
   logic           w_hs;

   assign w_ref = r_a * Y_W'(K);
   assign w_hs  = (r_state == DONE) && out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fail <= 1'b0;
      end else if (w_hs && (r_acc != w_ref)) begin
         r_fail <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && w_hs) begin
         assert (r_acc == w_ref)
            else $error("const_mult_seq: shift-add result disagrees with reference product");
      end
   end

   assign fail = r_fail;
`endif

endmodule
`default_nettype wire

// File: tb/tb_const_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_const_mult_seq                                                    |
// | Directed self-checking bench for K=21, K=0 and K=1 instances.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_const_mult_seq;

   logic clk;
   logic rst_n;

   logic        in_vld21, in_rdy21, out_vld21, out_rdy21, busy21;
   logic [31:0] in_a21;
   logic [36:0] out_y21;
   logic        in_vld0, in_rdy0, out_vld0, out_rdy0, busy0;
   logic [31:0] in_a0;
   logic [32:0] out_y0;
   logic        in_vld1, in_rdy1, out_vld1, out_rdy1, busy1;
   logic [31:0] in_a1;
   logic [32:0] out_y1;
`ifdef CONST_MULT_SEQ_CHECK_EN
   logic fail21, fail0, fail1;
`endif

   int tests_run;
   int tests_failed;

   const_mult_seq #(.W(32), .K(21)) u_dut21 (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld21), .in_rdy(in_rdy21), .in_a(in_a21),
      .out_vld(out_vld21), .out_rdy(out_rdy21), .out_y(out_y21), .busy(busy21)
`ifdef CONST_MULT_SEQ_CHECK_EN
      , .fail(fail21)
`endif
   );

   const_mult_seq #(.W(32), .K(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld0), .in_rdy(in_rdy0), .in_a(in_a0),
      .out_vld(out_vld0), .out_rdy(out_rdy0), .out_y(out_y0), .busy(busy0)
`ifdef CONST_MULT_SEQ_CHECK_EN
      , .fail(fail0)
`endif
   );

   const_mult_seq #(.W(32), .K(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_a(in_a1),
      .out_vld(out_vld1), .out_rdy(out_rdy1), .out_y(out_y1), .busy(busy1)
`ifdef CONST_MULT_SEQ_CHECK_EN
      , .fail(fail1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one operand into the K=21 unit (assumed idle) and returns the
   // cycle on which out_vld was first seen, with the accept edge as cycle 0.
   task automatic op21(input logic [31:0] a, output int lat, output logic [36:0] y,
                       output logic rdy_seen);
      in_a21   = a;
      in_vld21 = 1'b1;
      @(posedge clk); #1;
      in_vld21 = 1'b0;
      lat      = 1;
      rdy_seen = in_rdy21;
      while (!out_vld21 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         rdy_seen = rdy_seen | in_rdy21;
      end
      y = out_y21;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({in_rdy21, out_vld21, busy21} !== 3'b100 || out_y21 !== 37'd0) begin
         tests_failed++;
         $display("FAIL reset_in_reset: rdy/vld/busy=%b y=%0h, expected 100 y=0",
                  {in_rdy21, out_vld21, busy21}, out_y21);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({in_rdy21, out_vld21, busy21} !== 3'b100 || out_y21 !== 37'd0 ||
          {in_rdy0, out_vld0, busy0, in_rdy1, out_vld1, busy1} !== 6'b100100) begin
         tests_failed++;
         $display("FAIL reset_after_release: k21=%b k0=%b k1=%b, expected 100 each",
                  {in_rdy21, out_vld21, busy21}, {in_rdy0, out_vld0, busy0},
                  {in_rdy1, out_vld1, busy1});
      end
   endtask

   task automatic test_basic;
      int lat; logic [36:0] y; logic rdy_seen;
      out_rdy21 = 1'b1;
      op21(32'd3, lat, y, rdy_seen);
      tests_run++;
      if (lat !== 4) begin
         tests_failed++;
         $display("FAIL basic_latency: got %0d, expected 4", lat);
      end
      tests_run++;
      if (y !== 37'd63) begin
         tests_failed++;
         $display("FAIL basic_value: got %0d, expected 63", y);
      end
      tests_run++;
      if (rdy_seen !== 1'b0 || busy21 !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_in_rdy_low: rdy_seen=%b busy=%b, expected 0 and 1", rdy_seen, busy21);
      end
      @(posedge clk); #1;
      tests_run++;
      if (in_rdy21 !== 1'b1 || out_vld21 !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_return_idle: in_rdy=%b out_vld=%b, expected 1 0", in_rdy21, out_vld21);
      end
   endtask

   task automatic test_no_trunc;
      int lat; logic [36:0] y; logic rdy_seen;
      out_rdy21 = 1'b1;
      op21(32'hFFFF_FFFF, lat, y, rdy_seen);
      tests_run++;
      if (y !== 37'h14_FFFF_FFEB) begin
         tests_failed++;
         $display("FAIL no_trunc: got %h, expected 14ffffffeb", y);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int lat; logic [36:0] y; logic rdy_seen;
      out_rdy21 = 1'b0;
      op21(32'd5, lat, y, rdy_seen);
      tests_run++;
      if (y !== 37'd105 || lat !== 4) begin
         tests_failed++;
         $display("FAIL bp_first: y=%0d lat=%0d, expected 105 and 4", y, lat);
      end
      in_a21   = 32'd9;
      in_vld21 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_vld21 !== 1'b1 || out_y21 !== 37'd105 || in_rdy21 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: vld=%b y=%0d rdy=%b, expected 1 105 0",
                     i, out_vld21, out_y21, in_rdy21);
         end
      end
      in_vld21  = 1'b0;
      out_rdy21 = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (out_vld21 !== 1'b0 || in_rdy21 !== 1'b1 || busy21 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release: vld=%b rdy=%b busy=%b, expected 0 1 0",
                  out_vld21, in_rdy21, busy21);
      end
   endtask

   task automatic test_k0_k1;
      int lat0, lat1;
      out_rdy0 = 1'b1;
      out_rdy1 = 1'b1;
      in_a0 = 32'h1234; in_vld0 = 1'b1;
      in_a1 = 32'h1234; in_vld1 = 1'b1;
      @(posedge clk); #1;
      in_vld0 = 1'b0; in_vld1 = 1'b0;
      lat0 = out_vld0 ? 1 : 0;
      lat1 = out_vld1 ? 1 : 0;
      tests_run++;
      if (out_vld0 !== 1'b1 || out_y0 !== 33'd0) begin
         tests_failed++;
         $display("FAIL k0_cycle1: vld=%b y=%h, expected 1 0", out_vld0, out_y0);
      end
      for (int c = 2; c < 10 && lat1 == 0; c++) begin
         @(posedge clk); #1;
         if (out_vld1) lat1 = c;
      end
      tests_run++;
      if (lat1 !== 2 || out_y1 !== 33'h1234) begin
         tests_failed++;
         $display("FAIL k1_result: lat=%0d y=%h, expected 2 1234", lat1, out_y1);
      end
      tests_run++;
      if (lat0 !== 1) begin
         tests_failed++;
         $display("FAIL k0_latency: got %0d, expected 1", lat0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int lat; logic [36:0] y; logic rdy_seen;
      out_rdy21 = 1'b1;
      in_a21    = 32'd7;
      in_vld21  = 1'b1;
      @(posedge clk); #1;
      in_vld21 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_vld21 !== 1'b0 || busy21 !== 1'b0 || in_rdy21 !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_async: vld=%b busy=%b rdy=%b, expected 0 0 1",
                  out_vld21, busy21, in_rdy21);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (out_vld21 !== 1'b0 || busy21 !== 1'b0 || in_rdy21 !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_release: vld=%b busy=%b rdy=%b, expected 0 0 1",
                  out_vld21, busy21, in_rdy21);
      end
      op21(32'd2, lat, y, rdy_seen);
      tests_run++;
      if (y !== 37'd42 || lat !== 4) begin
         tests_failed++;
         $display("FAIL rst_mid_next: y=%0d lat=%0d, expected 42 and 4", y, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic exp_vld, exp_rdy;
      out_rdy21 = 1'b1;
      in_a21    = 32'd10;
      in_vld21  = 1'b1;
      @(posedge clk); #1;
      in_a21 = 32'd11;
      for (int c = 1; c <= 10; c++) begin
         exp_vld = (c == 4) || (c == 9);
         exp_rdy = (c == 5) || (c == 10);
         tests_run++;
         if (out_vld21 !== exp_vld || in_rdy21 !== exp_rdy) begin
            tests_failed++;
            $display("FAIL b2b_cycle%0d: vld=%b rdy=%b, expected %b %b",
                     c, out_vld21, in_rdy21, exp_vld, exp_rdy);
         end
         if (c == 4 || c == 9) begin
            tests_run++;
            if (out_y21 !== ((c == 4) ? 37'd210 : 37'd231)) begin
               tests_failed++;
               $display("FAIL b2b_value%0d: got %0d, expected %0d",
                        c, out_y21, (c == 4) ? 210 : 231);
            end
         end
         if (c == 9) in_vld21 = 1'b0;
         @(posedge clk); #1;
      end
   endtask

`ifdef CONST_MULT_SEQ_CHECK_EN
   task automatic test_check;
      logic [31:0] a;
      logic [36:0] exp_y;
      int          bad;
      int          n;
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         a        = $urandom;
         exp_y    = {5'd0, a} * 37'd21;
         in_a21   = a;
         in_vld21 = 1'b1;
         @(posedge clk); #1;
         in_vld21 = 1'b0;
         n = 0;
         while (n < 100) begin
            out_rdy21 = 1'($urandom_range(0, 1));
            if (out_vld21 && out_rdy21) begin
               if (out_y21 !== exp_y) bad++;
               n = 1000;
            end else begin
               n++;
            end
            @(posedge clk); #1;
         end
         if (n != 1000) bad++;
      end
      tests_run++;
      if (bad !== 0 || fail21 !== 1'b0) begin
         tests_failed++;
         $display("FAIL check_random: bad=%0d fail=%b, expected 0 0", bad, fail21);
      end
      out_rdy21 = 1'b0;
      in_a21    = 32'd4;
      in_vld21  = 1'b1;
      @(posedge clk); #1;
      in_vld21 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      force u_dut21.r_acc = 37'd1;
      out_rdy21 = 1'b1;
      @(posedge clk); #1;
      release u_dut21.r_acc;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (fail21 !== 1'b1) begin
         tests_failed++;
         $display("FAIL check_sticky: fail=%b, expected 1", fail21);
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      in_vld21 = 1'b0; in_a21 = '0; out_rdy21 = 1'b1;
      in_vld0  = 1'b0; in_a0  = '0; out_rdy0  = 1'b1;
      in_vld1  = 1'b0; in_a1  = '0; out_rdy1  = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_no_trunc();
      test_backpressure();
      test_k0_k1();
      test_reset_mid();
      test_back_to_back();
`ifdef CONST_MULT_SEQ_CHECK_EN
      test_check();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/const_mult_seq.md
Name: const_mult_seq

Overview:
- Sequential multiply-by-constant unit. It computes y = a * K using shift-add.
- Each cycle it adds `a << i` for one set bit i of the elaboration-time constant K, so it needs no hardware multiplier.
- It is the parametrised, handshaked successor to the combinational fixed-factor multiplier.
- It sits between a valid/ready producer and consumer, for example in address-scaling or checksum datapaths.

Parameters:
- W, 32: operand width in bits.
- K, 21: constant multiplication factor. Unsigned, 0 <= K < 2**31.
- Y_W, derived localparam, W + $clog2(K+1) (minimum 1 added bit): result width. It is never overridden.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vld  in  1  operand valid.
- in_rdy  out  1  unit can accept an operand.
- in_a  in  W  unsigned operand.
- out_vld  out  1  result valid.
- out_rdy  in  1  consumer accepts the result.
- out_y  out  Y_W  product a*K, zero-extended; it never truncates.
- busy  out  1  the FSM is not in IDLE.
- fail  out  1  sticky self-check error. This port exists only when the macro is defined (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE.
  - in_rdy=1 after reset, since it is combinational from IDLE.
  - out_vld=0, out_y=0, busy=0, fail=0.
  - The accumulator, operand register and pending-bit mask all clear to 0.
- Reset asserted mid-operation discards the in-flight operand. No output is produced for it.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_rdy=1.
  - On in_vld: register in_a (zero-extended to Y_W), set acc=0 and mask=K.
  - Next state is ACCUM if K!=0, else DONE.
- ACCUM:
  - in_rdy=0.
  - Each cycle: i = index of the lowest set bit of mask; acc += (Y_W'(a_reg) << i); clear mask[i].
  - Extend before shifting. Shifting before extending is wrong because it truncates.
  - When the bit cleared is the last set bit in mask, go to DONE.
- DONE:
  - out_vld=1 and out_y=acc. Both are held stable while out_rdy=0.
  - On out_rdy, go to IDLE.
- Latency:
  - The accept edge is cycle 0.
  - out_vld rises at cycle popcount(K)+1, or cycle 1 when K=0.
- Throughput:
  - With no backpressure, one result every popcount(K)+2 cycles.
  - in_rdy is high only in IDLE. There is no accept in the same cycle as an output handshake.
- K=0: out_y=0 and latency is 1.
- K=1: out_y=a and latency is 2.
- The arithmetic is unsigned and modulo 2**Y_W. By construction of Y_W it never overflows.
- in_a is sampled only on the accept edge. Changes at other times are ignored.
- in_vld while busy is legal. It is held off by in_rdy=0.
- busy = (state != IDLE).

Optional Feature:
- Macro: CONST_MULT_SEQ_CHECK_EN.
- Defined:
  - On every DONE-to-IDLE handshake, compare acc against a_reg*K, computed with the `*` operator.
  - On mismatch, set fail=1. It stays set until rst_n.
  - A simulation-only assertion also fires.
- Undefined: the reference product and the fail port are not compiled. There is no area cost.

Decomposition:
- Package const_mult_pkg holds:
  - state enum state_t {IDLE, ACCUM, DONE}.
  - function popcount(int) for elaboration-time latency.
  - function y_width(W, K) returning the Y_W value.
- One sub-module: const_mult_lsb_sel, a parametrised lowest-set-bit priority encoder. It takes a mask and returns the index and a last-bit flag.

Test Plan:
- W=32, K=21, a=3, out_rdy=1 -> out_vld at cycle 4, out_y=63; in_rdy low for cycles 1-4.
- W=32, K=21, a=0xFFFF_FFFF -> out_y=0x14_FFFF_FFEB (37 bits). No truncation.
- K=21, a=5, out_rdy held 0 for 10 cycles -> out_y=105 stable, out_vld held; a second in_vld during that time is not accepted.
- K=0, a=0x1234 -> out_y=0 at cycle 1. K=1, a=0x1234 -> out_y=0x1234 at cycle 2.
- K=21, accept a=7, assert rst_n=0 at cycle 2 -> out_vld=0, busy=0, in_rdy=1 after release; the next operand a=2 yields 42.
- CONST_MULT_SEQ_CHECK_EN defined, 1000 random a values with random out_rdy -> fail stays 0. A forced acc corruption sets fail=1 and it stays set.
